// File: rtl/show_sel_scheduler.sv
// Display source scheduler: picks which of two values the board display shows,
// switching on a debounced button (manual) or a dwell timer (auto), with freeze.
module show_sel_scheduler #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned DWELL     = 50000000,
    parameter int unsigned DB_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             btn,
    input  logic             auto_en,
    input  logic             freeze,
    output logic             sel,
    output logic [WIDTH-1:0] show,
    output logic             sel_pulse
);

    localparam int unsigned DWELL_W = $clog2(DWELL);
    localparam int unsigned DB_W    = $clog2(DB_CYCLES);

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);
    localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DB_CYCLES - 1);

    logic               btn_s1;
    logic               btn_s2;
    logic [DB_W-1:0]    db_cnt;
    logic               db_lvl;
    logic               db_prev;
    logic [DWELL_W-1:0] dwell_cnt;
    logic               press;
    logic               expiry;
    logic               tog;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
        end else begin
            btn_s1 <= btn;
            btn_s2 <= btn_s1;
        end
    end

    // Level is accepted only after it has differed for DB_CYCLES consecutive cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt  <= '0;
            db_lvl  <= 1'b0;
            db_prev <= 1'b0;
        end else begin
            db_prev <= db_lvl;
            if (btn_s2 == db_lvl) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_lvl <= btn_s2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // Press and expiry are OR-ed so a coincident pair yields one toggle.
    always_comb begin
        press  = db_lvl & ~db_prev;
        expiry = auto_en & (dwell_cnt == DWELL_LAST);
        tog    = ~freeze & (press | expiry);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_cnt <= '0;
        end else if (freeze) begin
            dwell_cnt <= dwell_cnt;
        end else if (!auto_en || press || dwell_cnt == DWELL_LAST) begin
            dwell_cnt <= '0;
        end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel       <= 1'b0;
            sel_pulse <= 1'b0;
            show      <= '0;
        end else begin
            sel       <= sel ^ tog;
            sel_pulse <= tog;
            if (!freeze) begin
                show <= sel ? in1 : in0;
            end
        end
    end

endmodule
